// File: rtl/video_out_stage_pkg.sv
// Shared video constants, mode/FSM encodings and the per-mode pixel function.
package video_out_stage_pkg;

  localparam int H_DISPLAY_DEF = 256;
  localparam int V_DISPLAY_DEF = 240;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_BORDER = 2'd2,
    MODE_BLACK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    DB_IDLE  = 2'd0,
    DB_COUNT = 2'd1,
    DB_HELD  = 2'd2
  } db_state_t;

  // Pixel before blanking; on_border marks the outermost ring of the raster.
  function automatic logic [2:0] mode_pixel(input mode_t m, input logic on_border,
                                            input logic [2:0] rgb);
    case (m)
      MODE_PASS:   return rgb;
      MODE_INVERT: return ~rgb;
      MODE_BORDER: return on_border ? 3'b111 : rgb;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/video_out_stage_frame_debounce.sv
// Frame-rate button debouncer: a press needs DEBOUNCE_FRAMES consecutive
// high samples taken on tick; a held button produces a single press.
module frame_debounce
  import video_out_stage_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);

  db_state_t     state;
  logic [CW-1:0] count;
  logic [CW:0]   count_nxt;
  logic          reach;

  // Next count and press; press is combinational so mode moves in the same
  // cycle the FSM enters HELD.
  always_comb begin
    count_nxt = (state == DB_COUNT) ? ({1'b0, count} + (CW+1)'(1)) : (CW+1)'(1);
    reach     = (count_nxt >= (CW+1)'(DEBOUNCE_FRAMES));
    press     = tick && btn && (state != DB_HELD) && reach;
  end

  // Debounce FSM, advanced only on frame ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DB_IDLE;
      count <= '0;
    end else if (tick) begin
      case (state)
        DB_IDLE, DB_COUNT: begin
          if (btn) begin
            state <= reach ? DB_HELD : DB_COUNT;
            count <= count_nxt[CW-1:0];
          end else begin
            state <= DB_IDLE;
            count <= '0;
          end
        end
        DB_HELD: begin
          if (!btn) begin
            state <= DB_IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= DB_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/video_out_stage.sv
// Video output stage: two-stage pixel/sync pipeline with mode-dependent
// pixel shaping, blanking, frame counting and a debounced mode button.
module video_out_stage
  import video_out_stage_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on_in,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic [2:0] rgb_in,
  input  logic       mode_btn,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [2:0] rgb_out,
  output logic [1:0] mode,
  output logic [7:0] frame_count
);

  logic       btn_meta, btn_sync;
  logic       vsync_prev, tick, press;
  logic       on_border;
  logic       s1_hs, s1_vs, s1_on;
  logic [2:0] s1_px;

  assign tick      = vsync_in & ~vsync_prev;
  assign on_border = (hpos == 9'd0) || (hpos == 9'(H_DISPLAY - 1)) ||
                     (vpos == 9'd0) || (vpos == 9'(V_DISPLAY - 1));

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= mode_btn;
      btn_sync <= btn_meta;
    end
  end

  frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (btn_sync),
    .press (press)
  );

  // Vsync edge detect, frame counter and mode register (frame-boundary only).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_prev  <= 1'b0;
      frame_count <= '0;
      mode        <= MODE_PASS;
    end else begin
      vsync_prev <= vsync_in;
      if (tick)  frame_count <= frame_count + 8'd1;
      if (press) mode        <= mode + 2'd1;
    end
  end

  // Stage 1: register syncs and the mode-shaped pixel from same-cycle hpos/vpos.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_on <= 1'b0;
      s1_px <= '0;
    end else begin
      s1_hs <= hsync_in;
      s1_vs <= vsync_in;
      s1_on <= display_on_in;
      s1_px <= mode_pixel(mode_t'(mode), on_border, rgb_in);
    end
  end

  // Stage 2: outputs, blanking applied with the delayed display flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb_out   <= '0;
    end else begin
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
      rgb_out   <= s1_on ? s1_px : 3'b000;
    end
  end

endmodule

// File: tb/tb_video_out_stage.sv
// Bench for video_out_stage: scoreboard of expected {hsync,vsync,rgb} pushed
// at drive time and popped two cycles later; frame/mode behaviour checked inline.
module tb_video_out_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync_in, vsync_in, display_on_in, mode_btn;
  logic [8:0] hpos, vpos;
  logic [2:0] rgb_in;
  logic       hsync_out, vsync_out;
  logic [2:0] rgb_out;
  logic [1:0] mode;
  logic [7:0] frame_count;

  typedef struct {
    logic       hs, vs, on;
    logic [8:0] h, v;
    logic [2:0] rgb;
  } vec_t;

  logic [4:0] sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_mode = 2'd0;

  video_out_stage dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on_in(display_on_in), .hpos(hpos), .vpos(vpos), .rgb_in(rgb_in),
    .mode_btn(mode_btn), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .rgb_out(rgb_out), .mode(mode), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model(input logic [1:0] m, input logic on,
                                       input logic [8:0] h, input logic [8:0] v,
                                       input logic [2:0] c);
    if (!on) return 3'b000;
    case (m)
      2'd0: return c;
      2'd1: return ~c;
      2'd2: return (h == 9'd0 || h == 9'd255 || v == 9'd0 || v == 9'd239) ? 3'b111 : c;
      default: return 3'b000;
    endcase
  endfunction

  task automatic apply(input vec_t t);
    hsync_in = t.hs; vsync_in = t.vs; display_on_in = t.on;
    hpos = t.h; vpos = t.v; rgb_in = t.rgb;
    sb.push_back({t.hs, t.vs, model(exp_mode, t.on, t.h, t.v, t.rgb)});
  endtask

  function automatic vec_t rnd_vec();
    vec_t t;
    t.hs = 1'($urandom_range(0, 1)); t.vs = 1'($urandom_range(0, 1));
    t.on = 1'($urandom_range(0, 1));
    t.h = 9'($urandom_range(0, 300)); t.v = 9'($urandom_range(0, 260));
    t.rgb = 3'($urandom_range(0, 7));
    return t;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame_edge(input int high_cycles);
    vsync_in = 1'b1;
    cyc(high_cycles);
    vsync_in = 1'b0;
    cyc(1);
  endtask

  task automatic press_button();
    mode_btn = 1'b1; cyc(3);
    repeat (3) frame_edge(1);
    mode_btn = 1'b0; cyc(3);
    frame_edge(1);
    exp_mode = exp_mode + 2'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; display_on_in = 1'b1;
    hpos = 9'd3; vpos = 9'd3; rgb_in = 3'b111; mode_btn = 1'b1;
    cyc(3);
    checks += 5;
    if (hsync_out !== 1'b0) begin errors++; $display("FAIL reset_hsync actual=%b required=0", hsync_out); end
    if (vsync_out !== 1'b0) begin errors++; $display("FAIL reset_vsync actual=%b required=0", vsync_out); end
    if (rgb_out !== 3'b000) begin errors++; $display("FAIL reset_rgb actual=%b required=000", rgb_out); end
    if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode actual=%0d required=0", mode); end
    if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_fc actual=%0d required=0", frame_count); end
    hsync_in = 1'b0; vsync_in = 1'b0; display_on_in = 1'b0; rgb_in = 3'b000; mode_btn = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_frame_count();
    frame_edge(1);
    checks++;
    if (frame_count !== 8'd1) begin errors++; $display("FAIL fc_edge1 actual=%0d required=1", frame_count); end
    frame_edge(3);
    checks++;
    if (frame_count !== 8'd2) begin errors++; $display("FAIL fc_long_vsync actual=%0d required=2", frame_count); end
    repeat (254) frame_edge(1);
    checks++;
    if (frame_count !== 8'd0) begin errors++; $display("FAIL fc_wrap actual=%0d required=0", frame_count); end
  endtask

  task automatic test_pass();
    vec_t t;
    logic [4:0] e;
    checks++;
    if (mode !== exp_mode) begin errors++; $display("FAIL pass_mode actual=%0d required=%0d", mode, exp_mode); end
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        t = rnd_vec();
        if (i == 4) begin t.on = 1'b1; t.h = 9'd10; t.v = 9'd20; t.rgb = 3'b110; t.hs = 1'b1; t.vs = 1'b0; end
        apply(t);
      end
      cyc(1);
      if (sb.size() >= 2 || (i == 10 && sb.size() > 0)) begin
        e = sb.pop_front(); checks++;
        if ({hsync_out, vsync_out, rgb_out} !== e) begin
          errors++; $display("FAIL pass_px%0d actual=%b required=%b", i, {hsync_out, vsync_out, rgb_out}, e);
        end
      end
    end
    vsync_in = 1'b0; cyc(1);
  endtask

  task automatic test_blank();
    vec_t t;
    logic [4:0] e;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        t = rnd_vec(); t.on = 1'b0; t.rgb = 3'b111; t.vs = 1'b0;
        if (i == 1) begin t.h = 9'd0; t.v = 9'd0; end
        apply(t);
      end
      cyc(1);
      if (sb.size() >= 2 || (i == 4 && sb.size() > 0)) begin
        e = sb.pop_front(); checks++;
        if ({hsync_out, vsync_out, rgb_out} !== e) begin
          errors++; $display("FAIL blank_m%0d_px%0d actual=%b required=%b", exp_mode, i, {hsync_out, vsync_out, rgb_out}, e);
        end
      end
    end
  endtask

  task automatic test_debounce();
    mode_btn = 1'b1; cyc(3);
    frame_edge(1); frame_edge(1);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL db_edge2 actual=%0d required=0", mode); end
    frame_edge(1);
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL db_edge3 actual=%0d required=1", mode); end
    exp_mode = 2'd1;
    repeat (10) frame_edge(1);
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL db_held actual=%0d required=1", mode); end
    mode_btn = 1'b0; cyc(3); frame_edge(1);
    mode_btn = 1'b1; cyc(3);
    frame_edge(1); frame_edge(1);
    mode_btn = 1'b0; cyc(3);
    repeat (3) frame_edge(1);
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL db_short actual=%0d required=1", mode); end
  endtask

  task automatic test_invert();
    vec_t t;
    logic [4:0] e;
    checks++;
    if (mode !== exp_mode) begin errors++; $display("FAIL inv_mode actual=%0d required=%0d", mode, exp_mode); end
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin t = rnd_vec(); t.vs = 1'b0; t.on = (i != 2); apply(t); end
      cyc(1);
      if (sb.size() >= 2 || (i == 6 && sb.size() > 0)) begin
        e = sb.pop_front(); checks++;
        if ({hsync_out, vsync_out, rgb_out} !== e) begin
          errors++; $display("FAIL inv_px%0d actual=%b required=%b", i, {hsync_out, vsync_out, rgb_out}, e);
        end
      end
    end
  endtask

  task automatic test_border();
    vec_t t;
    logic [4:0] e;
    logic [8:0] hs_t[6] = '{9'd0, 9'd255, 9'd5, 9'd5, 9'd5, 9'd254};
    logic [8:0] vs_t[6] = '{9'd5, 9'd5, 9'd0, 9'd239, 9'd5, 9'd238};
    checks++;
    if (mode !== exp_mode) begin errors++; $display("FAIL bord_mode actual=%0d required=%0d", mode, exp_mode); end
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        t.hs = i[0]; t.vs = 1'b0; t.on = 1'b1; t.h = hs_t[i]; t.v = vs_t[i]; t.rgb = 3'b001;
        apply(t);
      end
      cyc(1);
      if (sb.size() >= 2 || (i == 6 && sb.size() > 0)) begin
        e = sb.pop_front(); checks++;
        if ({hsync_out, vsync_out, rgb_out} !== e) begin
          errors++; $display("FAIL bord_px%0d actual=%b required=%b", i, {hsync_out, vsync_out, rgb_out}, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    mode_btn = 1'b1; cyc(3);
    frame_edge(1); frame_edge(1);
    @(posedge clk); #3;
    reset = 1'b1; #1;
    checks += 2;
    if (mode !== 2'd0) begin errors++; $display("FAIL rst_async_mode actual=%0d required=0", mode); end
    if (frame_count !== 8'd0) begin errors++; $display("FAIL rst_async_fc actual=%0d required=0", frame_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_mode = 2'd0;
    cyc(3);
    frame_edge(1);
    checks++;
    if (frame_count !== 8'd1) begin errors++; $display("FAIL rst_fc_first actual=%0d required=1", frame_count); end
    frame_edge(1);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL rst_db_edge2 actual=%0d required=0", mode); end
    frame_edge(1);
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL rst_db_edge3 actual=%0d required=1", mode); end
    mode_btn = 1'b0;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_frame_count();
    test_pass();
    test_blank();
    test_debounce();
    test_invert();
    test_blank();
    press_button();
    test_border();
    test_blank();
    press_button();
    test_blank();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
